// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared FSM encodings, MAC term indices and accumulator sizing for the fan PID path.
package fan_ctrl_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MAC    = 3'd2;
    localparam logic [2:0] S_SAT    = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] T_B2 = 3'd0;
    localparam logic [2:0] T_B1 = 3'd1;
    localparam logic [2:0] T_B0 = 3'd2;
    localparam logic [2:0] T_A1 = 3'd3;
    localparam logic [2:0] T_A0 = 3'd4;
    // Product width plus three guard bits covers the sum of five products.
    function automatic int acc_width(input int reg_w, input int adc_w);
        return reg_w + adc_w + 1 + 3;
    endfunction
endpackage

// File: rtl/pid_mac_unit.sv
// pid_mac_unit: shared signed multiplier with optional product negate, accumulate and clear.
module pid_mac_unit #(
    parameter int COEF_W = 8,
    parameter int DATA_W = 5,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     add,
    input  logic                     neg,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [ACC_W-1:0]  acc
);
    localparam int PW = COEF_W + DATA_W;
    logic signed [PW-1:0] prod;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] term;
    assign prod = coef * data;
    assign ext  = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign term = neg ? -ext : ext;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= clr ? '0 : add ? acc + term : acc;
    end
endmodule

// File: rtl/pid_mac_scheduler.sv
// pid_mac_scheduler: time-multiplexed 2nd-order IIR/PID update with one shared multiplier.
module pid_mac_scheduler
    import fan_ctrl_pkg::*;
#(
    parameter int ADC_BITWIDTH  = 4,
    parameter int REG_BITWIDTH  = 8,
    parameter int FRAC_BITWIDTH = 6,
    parameter int TICK_DIV      = 200000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clk_en_i,
    input  logic                           trig_i,
    input  logic [ADC_BITWIDTH-1:0]        ADC_value_i,
    input  logic [ADC_BITWIDTH-1:0]        SET_value_i,
    input  logic signed [REG_BITWIDTH-1:0] b2_i,
    input  logic signed [REG_BITWIDTH-1:0] b1_i,
    input  logic signed [REG_BITWIDTH-1:0] b0_i,
    input  logic signed [REG_BITWIDTH-1:0] a1_i,
    input  logic signed [REG_BITWIDTH-1:0] a0_i,
    output logic signed [ADC_BITWIDTH:0]   PID_Val_o,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           sat_o,
    output logic                           overrun_o
);
    localparam int EW    = ADC_BITWIDTH + 1;
    localparam int ACC_W = acc_width(REG_BITWIDTH, ADC_BITWIDTH);
    localparam int CW    = $clog2(TICK_DIV);
    localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((2 ** ADC_BITWIDTH) - 1);
    localparam logic signed [ACC_W-1:0] R_MIN = ACC_W'(-(2 ** ADC_BITWIDTH));

    logic [CW-1:0] cnt;
    logic tick, req;
    logic [2:0] state, term;
    logic signed [EW-1:0] e_now, e, x1, x2, y1, y2, y_sat, y_q, mul_data;
    logic signed [REG_BITWIDTH-1:0] mul_coef;
    logic signed [ACC_W-1:0] acc, r;
    logic clip_hi, clip_lo, sat_q;

    assign tick   = cnt == CW'(TICK_DIV - 1);
    assign req    = tick | trig_i;
    assign busy_o = state != S_IDLE;
    assign e_now  = $signed({1'b0, SET_value_i}) - $signed({1'b0, ADC_value_i});
    assign r      = acc >>> FRAC_BITWIDTH;

    always_comb begin
        mul_coef = term == T_B2 ? b2_i : term == T_B1 ? b1_i : term == T_B0 ? b0_i :
                   term == T_A1 ? a1_i : a0_i;
        mul_data = term == T_B2 ? e : term == T_B1 ? x1 : term == T_B0 ? x2 :
                   term == T_A1 ? y1 : y2;
        clip_hi  = r > R_MAX;
        clip_lo  = r < R_MIN;
        y_sat    = clip_hi ? {1'b0, {ADC_BITWIDTH{1'b1}}} :
                   clip_lo ? {1'b1, {ADC_BITWIDTH{1'b0}}} : r[EW-1:0];
    end

    pid_mac_unit #(
        .COEF_W(REG_BITWIDTH),
        .DATA_W(EW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk_i),
        .rst (rst_i),
        .en  (clk_en_i),
        .clr (state == S_LOAD),
        .add (state == S_MAC),
        .neg (term >= T_A1),
        .coef(mul_coef),
        .data(mul_data),
        .acc (acc)
    );

    // A request landing in UPDATE chains straight into the next step so TICK_DIV=8 sustains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            state     <= S_IDLE;
            term      <= T_B2;
            e         <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            y_q       <= '0;
            sat_q     <= 1'b0;
            PID_Val_o <= '0;
            valid_o   <= 1'b0;
            sat_o     <= 1'b0;
            overrun_o <= 1'b0;
        end else if (clk_en_i) begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            valid_o <= 1'b0;
            if (req && busy_o && state != S_UPDATE)
                overrun_o <= 1'b1;
            case (state)
                S_IDLE: if (req) state <= S_LOAD;
                S_LOAD: begin
                    e     <= e_now;
                    term  <= T_B2;
                    state <= S_MAC;
                end
                S_MAC: begin
                    term <= term + 3'd1;
                    if (term == T_A0)
                        state <= S_SAT;
                end
                S_SAT: begin
                    y_q   <= y_sat;
                    sat_q <= clip_hi | clip_lo;
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    x2        <= x1;
                    x1        <= e;
                    y2        <= y1;
                    y1        <= y_q;
                    PID_Val_o <= y_q;
                    sat_o     <= sat_q;
                    valid_o   <= 1'b1;
                    state     <= req ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pid_mac_scheduler.sv
// tb_pid_mac_scheduler: directed checks of step results, latency, stall, overrun and async reset.
module tb_pid_mac_scheduler;
    logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, trig = 1'b0;
    logic [3:0] adc = 4'd0, set = 4'd0;
    logic signed [7:0] b2 = 8'sd94, b1 = 8'sd0, b0 = -8'sd93, a1 = 8'sd0, a0 = -8'sd64;
    logic signed [4:0] pid;
    logic valid, busy, sat, overrun;
    int checks = 0, errors = 0;
    int n;

    always #5 clk = ~clk;

    pid_mac_scheduler #(.TICK_DIV(8)) dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .trig_i(trig),
        .ADC_value_i(adc), .SET_value_i(set),
        .b2_i(b2), .b1_i(b1), .b0_i(b0), .a1_i(a1), .a0_i(a0),
        .PID_Val_o(pid), .valid_o(valid), .busy_o(busy), .sat_o(sat), .overrun_o(overrun)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid && cnt < 40);
    endtask

    task automatic step(input string tag, input int exp_pid, input int exp_sat, input int exp_lat);
        int k;
        wait_valid(k);
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_pid"}, 32'(pid), exp_pid);
        chk({tag, "_sat"}, 32'(sat), exp_sat);
    endtask

    task automatic do_reset(input logic [3:0] s, input logic [3:0] a);
        @(negedge clk);
        #2 rst = 1'b1;
        set = s;
        adc = a;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_pid", 32'(pid), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_overrun", 32'(overrun), 0);

        set = 4'd5;
        adc = 4'd5;
        @(negedge clk);
        rst = 1'b0;
        step("t1a", 0, 0, 16);
        step("t1b", 0, 0, 8);
        step("t1c", 0, 0, 8);
        chk("t1_overrun", 32'(overrun), 0);

        do_reset(4'd3, 4'd0);
        step("t2a", 4, 0, 16);
        step("t2b", 4, 0, 8);
        step("t2c", 4, 0, 8);

        do_reset(4'd15, 4'd0);
        step("t3pos", 15, 1, 16);
        do_reset(4'd0, 4'd15);
        step("t3neg", -16, 1, 16);

        do_reset(4'd3, 4'd0);
        repeat (11) @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_busy", 32'(busy), 1);
        clk_en = 1'b1;
        wait_valid(n);
        chk("t4_lat", n + 16, 21);
        chk("t4_pid", 32'(pid), 4);
        step("t4b", 4, 0, 8);

        do_reset(4'd3, 4'd0);
        repeat (10) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        chk("t5_overrun", 32'(overrun), 1);
        wait_valid(n);
        chk("t5_lat", n + 11, 16);
        chk("t5_pid", 32'(pid), 4);
        step("t5b", 4, 0, 8);
        chk("t5_sticky", 32'(overrun), 1);

        do_reset(4'd15, 4'd0);
        chk("t6_ovr_clr", 32'(overrun), 0);
        step("t6a", 15, 1, 16);
        step("t6b", 15, 1, 8);
        repeat (11) @(negedge clk);
        chk("t6_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_pid", 32'(pid), 0);
        chk("t6_busy0", 32'(busy), 0);
        chk("t6_sat", 32'(sat), 0);
        chk("t6_valid", 32'(valid), 0);
        set = 4'd3;
        adc = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        step("t6c", 4, 0, 16);
        step("t6d", 4, 0, 8);
        step("t6e", 4, 0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
